regfile_wb_arbiter: RTL

Shares the register file's single write port among N writeback requesters (ALU, load unit, multiplier) and tracks outstanding destination registers in a 32-entry scoreboard. It sits between the execution units and the register file. Each cycle it grants at most one requester by round-robin and drives the registered `regwrite`/`wr`/`write_data` triple into the register file. The issue stage uses its hazard output to stall on pending source registers.

---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among N
// writeback requesters, with a 32-entry scoreboard of outstanding destinations.
module regfile_wb_arbiter #(
  parameter int W = 32,
  parameter int N = 3
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [N-1:0]   req_valid,
  input  logic [5*N-1:0] req_rd,
  input  logic [W*N-1:0] req_data,
  output logic [N-1:0]   req_ready,
  input  logic           issue_valid,
  input  logic [4:0]     issue_rd,
  input  logic [4:0]     chk_rs1,
  input  logic [4:0]     chk_rs2,
  output logic           hazard,
  output logic           rf_regwrite,
  output logic [4:0]     rf_wr,
  output logic [W-1:0]   rf_wdata,
  output logic [31:0]    pending
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] r_ptr;
  logic [31:0]   r_pending;
  logic          r_regwrite;
  logic [4:0]    r_wr;
  logic [W-1:0]  r_wdata;

  logic          w_gnt_vld;
  logic [PW-1:0] w_gnt_idx;
  logic [N-1:0]  w_gnt;
  logic [4:0]    w_rd;
  logic [W-1:0]  w_data;
  logic [31:0]   w_pending_nxt;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // Search from ptr upward, wrapping; nothing is granted while in reset.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (reset_n) begin
      for (int k = 0; k < N; k++) begin
        if (!w_gnt_vld && req_valid[wrap_add(r_ptr, k)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = wrap_add(r_ptr, k);
        end
      end
    end
  end

  always_comb begin
    w_gnt  = '0;
    w_rd   = '0;
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_vld && (w_gnt_idx == PW'(i))) begin
        w_gnt[i] = 1'b1;
        w_rd     = req_rd[5*i +: 5];
        w_data   = req_data[W*i +: W];
      end
    end
  end

  // Issue set is applied after the writeback clear so a same-edge reissue stays pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_gnt_vld)
      w_pending_nxt[w_rd] = 1'b0;
    if (issue_valid)
      w_pending_nxt[issue_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_pending  <= '0;
      r_regwrite <= 1'b0;
      r_wr       <= '0;
      r_wdata    <= '0;
    end else begin
      r_regwrite <= w_gnt_vld && (w_rd != 5'd0);
      r_pending  <= w_pending_nxt;
      if (w_gnt_vld) begin
        r_wr    <= w_rd;
        r_wdata <= w_data;
        r_ptr   <= wrap_add(w_gnt_idx, 1);
      end
    end
  end

  assign req_ready   = w_gnt;
  assign hazard      = ((chk_rs1 != 5'd0) && r_pending[chk_rs1]) ||
                       ((chk_rs2 != 5'd0) && r_pending[chk_rs2]);
  assign rf_regwrite = r_regwrite;
  assign rf_wr       = r_wr;
  assign rf_wdata    = r_wdata;
  assign pending     = r_pending;

endmodule
